pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
Supervisor and reset sequencer for the fabric PLL wrapper. It drives the PLL's `rst` input and watches its asynchronous `locked` output. On lock timeout it retries the PLL reset, and on loss of lock it re-sequences. Runs entirely on the free-running 50 MHz reference clock and issues a qualified reset/ready to downstream logic (UART/SSP), which re-synchronises `sys_rst` into its own domain.

Parameters:
RST_PULSE_CYCLES, 16, cycles `pll_rst` is held high per reset attempt (min 2)
LOCK_TIMEOUT_CYCLES, 50000, cycles allowed in WAIT_LOCK before the attempt fails (1 ms at 50 MHz)
LOCK_STABLE_CYCLES, 1024, consecutive synchronised-lock cycles required before RUN
MAX_RETRIES, 3, re-attempts after the first attempt before FAULT
SYNC_STAGES, 2, flops in the `locked` synchroniser (min 2)

Ports:
refclk  in  1  reference clock, single clock domain
rst  in  1  synchronous, active-high reset
enable  in  1  level; 1 = bring up and keep PLL running, 0 = hold PLL in reset
clear_fault  in  1  single-cycle pulse; leaves FAULT
pll_locked  in  1  raw PLL `locked`, asynchronous
pll_rst  out  1  to PLL `rst`, registered
sys_rst  out  1  downstream reset, active high, registered
ready  out  1  PLL locked and stable, registered
fault  out  1  retries exhausted, registered
retry_cnt  out  2  retries used in current bring-up
lol_cnt  out  8  loss-of-lock events in RUN, saturating

Behaviour:
- Clock and reset: one clock, `refclk`; reset is synchronous and active-high, port name `rst`.
- `lock_s` is `pll_locked` after SYNC_STAGES flops. Synchroniser flops reset to 0.
- Outputs are registered and computed from next state, so they change on the same edge as the state register.
- Reset values: state IDLE, pll_rst=1, sys_rst=1, ready=0, fault=0, retry_cnt=0, lol_cnt=0, cycle counter=0.
- Single cycle counter `cnt`, width clog2 of the largest count parameter. It is cleared on every state transition.

State machine:
- IDLE: pll_rst=1, sys_rst=1.
  - `enable`=1 → PLL_RST; retry_cnt cleared.
- PLL_RST: pll_rst=1.
  - `cnt`==RST_PULSE_CYCLES-1 → WAIT_LOCK, so pll_rst is high exactly RST_PULSE_CYCLES cycles.
- WAIT_LOCK: pll_rst=0, sys_rst=1.
  - `lock_s`=1 → STABLE.
  - Else, `cnt`==LOCK_TIMEOUT_CYCLES-1: if retry_cnt==MAX_RETRIES → FAULT; otherwise retry_cnt+1 → PLL_RST.
- STABLE: pll_rst=0, sys_rst=1.
  - `lock_s`=0 → WAIT_LOCK with `cnt` restarted; this is not a retry.
  - `cnt`==LOCK_STABLE_CYCLES-1 with `lock_s`=1 → RUN.
- RUN: pll_rst=0, sys_rst=0, ready=1.
  - `lock_s`=0 → lol_cnt+1 (saturates at 255), retry_cnt cleared → PLL_RST.
- FAULT: pll_rst=1, sys_rst=1, fault=1.
  - `clear_fault`=1 → IDLE, fault=0, retry_cnt=0.
  - `enable` is ignored in FAULT.

Priority and boundary rules:
- Priority per edge: `rst` > `enable`=0 (any state except FAULT → IDLE) > state rules.
- In RUN, loss of lock and `enable`=0 on the same cycle → IDLE. lol_cnt still increments.
- `lock_s` rising on the timeout cycle in WAIT_LOCK: lock wins → STABLE.
- `rst` mid-operation returns everything to reset values on the next edge, including lol_cnt.
- retry_cnt never exceeds MAX_RETRIES.

Latency (nominal):
- `enable` sampled → pll_rst falls RST_PULSE_CYCLES+1 edges later.
- `pll_locked` rise → `lock_s` after SYNC_STAGES edges → STABLE next edge → ready LOCK_STABLE_CYCLES edges later.
- The `pll_locked` edge itself carries ±1 cycle of synchroniser uncertainty.

Decomposition:
- Shared package `pll_seq_pkg`: state enum (IDLE, PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT) and the LOL_CNT_W=8 and RETRY_W=2 constants.
- Sub-module `bit_sync`: parameterised SYNC_STAGES flop chain with synchronous reset. It is reused elsewhere for `sys_rst` consumers.

Test Plan:
Small parameters for the bench: RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2, SYNC_STAGES=2.
1. Normal bring-up: `enable`=1, `pll_locked` rises 5 cycles after pll_rst falls → pll_rst high exactly 4 cycles; ready=1 and sys_rst=0 on the 11th edge after `pll_locked` rises; retry_cnt=0.
2. Lock glitch: `pll_locked` drops for 3 cycles during STABLE cycle 5 → ready stays 0, retry_cnt=0, full 8-cycle stable window restarts after re-lock.
3. Timeout: `pll_locked` held 0 → exactly 3 pll_rst pulses of 4 cycles; retry_cnt goes 0→1→2; fault=1 after the third 20-cycle wait. `clear_fault` pulse → IDLE, fault=0, retry_cnt=0.
4. Loss of lock in RUN: `pll_locked` falls → 2-3 edges later lol_cnt=1, ready=0, sys_rst=1, new 4-cycle pll_rst pulse; re-lock → ready=1 again.
5. `rst` pulsed for one cycle mid-WAIT_LOCK with lol_cnt=1 → next edge pll_rst=1, sys_rst=1, ready=0, fault=0, lol_cnt=0, state IDLE.
6. Saturation: 260 RUN loss-of-lock events → lol_cnt stops at 255, no wrap; `enable`=0 in RUN → IDLE next edge with pll_rst=1.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// -----------------------------------------------------------------------------
// pll_seq_pkg
// Shared definitions for the PLL reset sequencer.
//   seq_state_t : sequencer states, IDLE through FAULT
//   LOL_CNT_W   : width of the saturating loss-of-lock event counter
//   RETRY_W     : width of the retry counter
//   max_of3()   : largest of three counts, used to size the shared cycle counter
// -----------------------------------------------------------------------------
package pll_seq_pkg;

   localparam int LOL_CNT_W = 8;
   localparam int RETRY_W   = 2;

   typedef enum logic [2:0] {
      IDLE,
      PLL_RST,
      WAIT_LOCK,
      STABLE,
      RUN,
      FAULT
   } seq_state_t;

   function automatic int max_of3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/bit_sync.sv
// -----------------------------------------------------------------------------
// bit_sync
// Multi-flop synchroniser for a single asynchronous level. Also used by the
// sys_rst consumers to bring the sequencer's reset into their own domain.
//   clk : destination clock
//   rst : synchronous, active-high reset; clears the whole chain to 0
//   d   : asynchronous input level
//   q   : d after STAGES flops
// -----------------------------------------------------------------------------
module bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   // Shift the raw level through the chain; only the last flop is consumed,
   // so the first one is allowed to go metastable.
   always_ff @(posedge clk) begin
      if (rst) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
// Supervises the fabric PLL: pulses its reset, waits for lock with a timeout
// and bounded retries, demands a stable lock window before releasing the
// downstream reset, and re-sequences on loss of lock.
//   refclk      : free-running reference clock (only clock)
//   rst         : synchronous, active-high reset
//   enable      : 1 = bring up / keep PLL running, 0 = hold PLL in reset
//   clear_fault : single-cycle pulse that leaves FAULT
//   pll_locked  : raw, asynchronous PLL lock indication
//   pll_rst     : registered reset to the PLL
//   sys_rst     : registered downstream reset, active high
//   ready       : registered, PLL locked and stable
//   fault       : registered, retries exhausted
//   retry_cnt   : retries used in the current bring-up
//   lol_cnt     : saturating count of loss-of-lock events seen in RUN
// -----------------------------------------------------------------------------
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int RST_PULSE_CYCLES    = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 50000,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int MAX_RETRIES         = 3,
   parameter int SYNC_STAGES         = 2
) (
   input  logic                 refclk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 clear_fault,
   input  logic                 pll_locked,
   output logic                 pll_rst,
   output logic                 sys_rst,
   output logic                 ready,
   output logic                 fault,
   output logic [RETRY_W-1:0]   retry_cnt,
   output logic [LOL_CNT_W-1:0] lol_cnt
);

   localparam int MAX_CNT = max_of3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
   localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

   localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

   seq_state_t           state, state_n;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic [RETRY_W-1:0]   retry_n;
   logic [LOL_CNT_W-1:0] lol_n;
   logic                 pll_rst_n, sys_rst_n, ready_n, fault_n;
   logic                 lock_s;

   bit_sync #(
      .STAGES(SYNC_STAGES)
   ) u_lock_sync (
      .clk(refclk),
      .rst(rst),
      .d  (pll_locked),
      .q  (lock_s)
   );

   // Next-state logic. enable=0 pulls every state except FAULT back to IDLE;
   // a lock loss in RUN on that same cycle is still counted. The cycle counter
   // only advances in the timed states and restarts on any state change.
   always_comb begin
      state_n = state;
      retry_n = retry_cnt;
      lol_n   = lol_cnt;
      cnt_n   = cnt;

      if (state == PLL_RST || state == WAIT_LOCK || state == STABLE) begin
         cnt_n = cnt + 1'b1;
      end

      if (!enable && state != FAULT) begin
         state_n = IDLE;
         if (state == RUN && !lock_s && lol_cnt != '1) begin
            lol_n = lol_cnt + 1'b1;
         end
      end else begin
         case (state)
            IDLE: begin
               state_n = PLL_RST;
               retry_n = '0;
            end
            PLL_RST: begin
               if (cnt == RST_LAST) state_n = WAIT_LOCK;
            end
            WAIT_LOCK: begin
               // Lock seen on the timeout cycle still counts as a success.
               if (lock_s) begin
                  state_n = STABLE;
               end else if (cnt == TIMEOUT_LAST) begin
                  if (retry_cnt == RETRY_LIMIT) begin
                     state_n = FAULT;
                  end else begin
                     state_n = PLL_RST;
                     retry_n = retry_cnt + 1'b1;
                  end
               end
            end
            STABLE: begin
               // A glitch just restarts the lock wait; it does not use a retry.
               if (!lock_s) begin
                  state_n = WAIT_LOCK;
               end else if (cnt == STABLE_LAST) begin
                  state_n = RUN;
               end
            end
            RUN: begin
               if (!lock_s) begin
                  state_n = PLL_RST;
                  retry_n = '0;
                  if (lol_cnt != '1) lol_n = lol_cnt + 1'b1;
               end
            end
            FAULT: begin
               if (clear_fault) begin
                  state_n = IDLE;
                  retry_n = '0;
               end
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end

      if (state_n != state) cnt_n = '0;
   end

   // Outputs are decoded from the next state so they move on the same edge
   // as the state register itself.
   always_comb begin
      pll_rst_n = (state_n == IDLE) || (state_n == PLL_RST) || (state_n == FAULT);
      sys_rst_n = (state_n != RUN);
      ready_n   = (state_n == RUN);
      fault_n   = (state_n == FAULT);
   end

   // State, counters and registered outputs.
   always_ff @(posedge refclk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         retry_cnt <= '0;
         lol_cnt   <= '0;
         pll_rst   <= 1'b1;
         sys_rst   <= 1'b1;
         ready     <= 1'b0;
         fault     <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         retry_cnt <= retry_n;
         lol_cnt   <= lol_n;
         pll_rst   <= pll_rst_n;
         sys_rst   <= sys_rst_n;
         ready     <= ready_n;
         fault     <= fault_n;
      end
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_sequencer
// Directed bench for pll_reset_sequencer using small timing parameters
// (pulse 4, timeout 20, stable window 8, 2 retries, 2 sync stages).
// -----------------------------------------------------------------------------
module tb_pll_reset_sequencer;
   import pll_seq_pkg::*;

   logic       refclk;
   logic       rst;
   logic       enable;
   logic       clear_fault;
   logic       pll_locked;
   logic       pll_rst;
   logic       sys_rst;
   logic       ready;
   logic       fault;
   logic [1:0] retry_cnt;
   logic [7:0] lol_cnt;

   int checks = 0;
   int errors = 0;

   pll_reset_sequencer #(
      .RST_PULSE_CYCLES   (4),
      .LOCK_TIMEOUT_CYCLES(20),
      .LOCK_STABLE_CYCLES (8),
      .MAX_RETRIES        (2),
      .SYNC_STAGES        (2)
   ) dut (
      .refclk     (refclk),
      .rst        (rst),
      .enable     (enable),
      .clear_fault(clear_fault),
      .pll_locked (pll_locked),
      .pll_rst    (pll_rst),
      .sys_rst    (sys_rst),
      .ready      (ready),
      .fault      (fault),
      .retry_cnt  (retry_cnt),
      .lol_cnt    (lol_cnt)
   );

   // 50 MHz reference clock.
   initial refclk = 1'b0;
   always #10 refclk = ~refclk;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic clr, input logic lk);
      enable      = en;
      clear_fault = clr;
      pll_locked  = lk;
   endtask

   // Advance one edge and settle just after it.
   task automatic tick();
      @(posedge refclk);
      #1;
   endtask

   task automatic waitPllRstLow(input string tag);
      int n;
      n = 0;
      while (pll_rst !== 1'b0 && n < 60) begin
         tick();
         n++;
      end
      checkOutput({tag, "_prst_low_wait"}, int'(pll_rst === 1'b0), 1);
   endtask

   task automatic waitReadyHigh(input string tag);
      int n;
      n = 0;
      while (ready !== 1'b1 && n < 60) begin
         tick();
         n++;
      end
      checkOutput({tag, "_ready_wait"}, int'(ready === 1'b1), 1);
   endtask

   task automatic bringUp(input string tag);
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitPllRstLow(tag);
      applyStimulus(1'b1, 1'b0, 1'b1);
      waitReadyHigh(tag);
   endtask

   initial begin
      int run;
      int pulses;
      int fault_edge;
      int exp_lol;
      logic prev;
      logic seen_ready;

      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick();
      tick();
      $display("[TB] reset values");
      checkOutput("rst_pll_rst", int'(pll_rst), 1);
      checkOutput("rst_sys_rst", int'(sys_rst), 1);
      checkOutput("rst_ready",   int'(ready), 0);
      checkOutput("rst_fault",   int'(fault), 0);
      checkOutput("rst_retry",   int'(retry_cnt), 0);
      checkOutput("rst_lol",     int'(lol_cnt), 0);
      rst = 1'b0;
      tick();

      // 1. Normal bring-up.
      $display("[TB] test 1: normal bring-up");
      applyStimulus(1'b1, 1'b0, 1'b0);
      tick();
      checkOutput("t1_prst_e0", int'(pll_rst), 1);
      for (int i = 1; i <= 3; i++) begin
         tick();
         checkOutput("t1_prst_held", int'(pll_rst), 1);
      end
      tick();
      checkOutput("t1_prst_fall_5th_edge", int'(pll_rst), 0);
      repeat (5) tick();
      checkOutput("t1_sys_rst_waiting", int'(sys_rst), 1);
      applyStimulus(1'b1, 1'b0, 1'b1);
      for (int i = 1; i <= 11; i++) begin
         tick();
         if (i == 10) checkOutput("t1_ready_edge10", int'(ready), 0);
      end
      checkOutput("t1_ready_edge11", int'(ready), 1);
      checkOutput("t1_sys_rst_edge11", int'(sys_rst), 0);
      checkOutput("t1_retry", int'(retry_cnt), 0);

      // 2. Lock glitch during the stable window.
      $display("[TB] test 2: lock glitch in STABLE");
      applyStimulus(1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("t2_disable_ready", int'(ready), 0);
      checkOutput("t2_disable_prst", int'(pll_rst), 1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick();
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitPllRstLow("t2");
      applyStimulus(1'b1, 1'b0, 1'b1);
      repeat (7) tick();
      seen_ready = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0);
      repeat (3) begin
         tick();
         seen_ready = seen_ready | ready;
      end
      applyStimulus(1'b1, 1'b0, 1'b1);
      for (int i = 1; i <= 11; i++) begin
         tick();
         if (i <= 10) seen_ready = seen_ready | ready;
      end
      checkOutput("t2_no_early_ready", int'(seen_ready), 0);
      checkOutput("t2_ready_after_window", int'(ready), 1);
      checkOutput("t2_retry", int'(retry_cnt), 0);

      // 3. Lock timeout, retries, fault and clear.
      $display("[TB] test 3: timeout and fault");
      applyStimulus(1'b0, 1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick();
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0);
      tick();
      checkOutput("t3_retry_e0", int'(retry_cnt), 0);
      run = 1;
      pulses = 0;
      fault_edge = -1;
      prev = pll_rst;
      for (int i = 1; i <= 72; i++) begin
         tick();
         if (prev && !pll_rst) begin
            checkOutput("t3_pulse_width", run, 4);
            pulses++;
         end
         if (!prev && pll_rst) begin
            run = 0;
            if (!fault) checkOutput("t3_retry_step", int'(retry_cnt), pulses);
         end
         if (pll_rst) run++;
         if (fault && fault_edge < 0) fault_edge = i;
         prev = pll_rst;
      end
      checkOutput("t3_pulse_count", pulses, 3);
      checkOutput("t3_fault_edge", fault_edge, 72);
      checkOutput("t3_retry_max", int'(retry_cnt), 2);
      checkOutput("t3_fault_prst", int'(pll_rst), 1);
      checkOutput("t3_fault_sys_rst", int'(sys_rst), 1);
      repeat (3) tick();
      checkOutput("t3_fault_holds_en1", int'(fault), 1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("t3_fault_holds_en0", int'(fault), 1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("t3_clear_fault", int'(fault), 0);
      checkOutput("t3_clear_retry", int'(retry_cnt), 0);
      checkOutput("t3_clear_prst", int'(pll_rst), 1);
      tick();
      checkOutput("t3_clear_state", int'(dut.state), int'(IDLE));

      // 4. Loss of lock in RUN.
      $display("[TB] test 4: loss of lock in RUN");
      bringUp("t4");
      applyStimulus(1'b1, 1'b0, 1'b0);
      tick();
      tick();
      checkOutput("t4_ready_edge2", int'(ready), 1);
      checkOutput("t4_lol_edge2", int'(lol_cnt), 0);
      tick();
      checkOutput("t4_ready_edge3", int'(ready), 0);
      checkOutput("t4_sys_rst_edge3", int'(sys_rst), 1);
      checkOutput("t4_prst_edge3", int'(pll_rst), 1);
      checkOutput("t4_lol_edge3", int'(lol_cnt), 1);
      run = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (pll_rst) run++;
      end
      tick();
      checkOutput("t4_pulse_width", run, 4);
      checkOutput("t4_prst_fall", int'(pll_rst), 0);
      applyStimulus(1'b1, 1'b0, 1'b1);
      waitReadyHigh("t4_relock");
      checkOutput("t4_relock_sys_rst", int'(sys_rst), 0);
      checkOutput("t4_relock_lol", int'(lol_cnt), 1);

      // 5. Reset in the middle of WAIT_LOCK.
      $display("[TB] test 5: rst mid WAIT_LOCK");
      applyStimulus(1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("t5_disable_prst", int'(pll_rst), 1);
      checkOutput("t5_disable_lol", int'(lol_cnt), 1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick();
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitPllRstLow("t5");
      tick();
      tick();
      checkOutput("t5_in_wait_lock", int'(dut.state), int'(WAIT_LOCK));
      checkOutput("t5_lol_before", int'(lol_cnt), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("t5_prst", int'(pll_rst), 1);
      checkOutput("t5_sys_rst", int'(sys_rst), 1);
      checkOutput("t5_ready", int'(ready), 0);
      checkOutput("t5_fault", int'(fault), 0);
      checkOutput("t5_lol", int'(lol_cnt), 0);
      checkOutput("t5_state", int'(dut.state), int'(IDLE));

      // 6. Loss of lock plus disable on one edge, then lol_cnt saturation.
      $display("[TB] test 6: lol_cnt saturation");
      exp_lol = 0;
      bringUp("t6_first");
      applyStimulus(1'b1, 1'b0, 1'b0);
      tick();
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick();
      exp_lol = 1;
      checkOutput("t6_combo_lol", int'(lol_cnt), exp_lol);
      checkOutput("t6_combo_state", int'(dut.state), int'(IDLE));
      checkOutput("t6_combo_prst", int'(pll_rst), 1);
      bringUp("t6_second");
      for (int ev = 2; ev <= 260; ev++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         repeat (3) tick();
         if (exp_lol < 255) exp_lol++;
         if (ev == 254 || ev == 255 || ev == 260) checkOutput("t6_lol", int'(lol_cnt), exp_lol);
         applyStimulus(1'b1, 1'b0, 1'b1);
         waitReadyHigh("t6_loop");
      end
      checkOutput("t6_lol_saturated", int'(lol_cnt), 255);
      applyStimulus(1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("t6_disable_prst", int'(pll_rst), 1);
      checkOutput("t6_disable_ready", int'(ready), 0);
      checkOutput("t6_disable_state", int'(dut.state), int'(IDLE));
      checkOutput("t6_disable_lol", int'(lol_cnt), 255);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
